// File: rtl/sd_arbiter_if.sv
// sd_arbiter bundle: two sector requesters plus the SD controller and
// sector-buffer paths. slave = arbiter view, master = requesters/controller.
interface sd_arbiter_if;
  logic        req0_rd;
  logic        req0_wr;
  logic        req1_rd;
  logic        req1_wr;
  logic [31:0] req0_lba;
  logic [31:0] req1_lba;
  logic        req0_wr_en;
  logic        req1_wr_en;
  logic [8:0]  req0_wr_addr;
  logic [8:0]  req1_wr_addr;
  logic [7:0]  req0_wr_data;
  logic [7:0]  req1_wr_data;
  logic [8:0]  req0_rd_addr;
  logic [8:0]  req1_rd_addr;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic        err0;
  logic        err1;
  logic [7:0]  rd_data;
  logic [31:0] sd_lba;
  logic        sd_rd_req;
  logic        sd_wr_req;
  logic        sd_wr_en;
  logic [8:0]  sd_wr_addr;
  logic [7:0]  sd_wr_data;
  logic [8:0]  sd_rd_addr;
  logic [7:0]  sd_rd_data;
  logic        sd_busy;
  logic        sd_done;

  modport slave (
    input  req0_rd, req0_wr, req1_rd, req1_wr,
    input  req0_lba, req1_lba,
    input  req0_wr_en, req1_wr_en,
    input  req0_wr_addr, req1_wr_addr,
    input  req0_wr_data, req1_wr_data,
    input  req0_rd_addr, req1_rd_addr,
    input  sd_rd_data, sd_busy, sd_done,
    output gnt0, gnt1, done0, done1, err0, err1,
    output rd_data, sd_lba, sd_rd_req, sd_wr_req,
    output sd_wr_en, sd_wr_addr, sd_wr_data, sd_rd_addr
  );

  modport master (
    output req0_rd, req0_wr, req1_rd, req1_wr,
    output req0_lba, req1_lba,
    output req0_wr_en, req1_wr_en,
    output req0_wr_addr, req1_wr_addr,
    output req0_wr_data, req1_wr_data,
    output req0_rd_addr, req1_rd_addr,
    output sd_rd_data, sd_busy, sd_done,
    input  gnt0, gnt1, done0, done1, err0, err1,
    input  rd_data, sd_lba, sd_rd_req, sd_wr_req,
    input  sd_wr_en, sd_wr_addr, sd_wr_data, sd_rd_addr
  );
endinterface

// File: rtl/sd_arbiter.sv
// Round-robin owner of the SD sector controller for two requesters.
// Ports: clk, rst (async, active-high), bus (sd_arbiter_if.slave).
module sd_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
  parameter int          SECTOR_BYTES   = 512
) (
  input logic         clk,
  input logic         rst,
  sd_arbiter_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, LOAD, ISSUE, WAIT, HOLD
  } state_t;

  localparam logic [9:0] LAST_STB =
    10'(SECTOR_BYTES - 1);
  localparam logic [23:0] TMO_LAST =
    TIMEOUT_CYCLES - 24'd1;

  state_t      state;
  logic        owner;
  logic        op_rd;
  logic        last_owner;
  logic [9:0]  strobes;
  logic [23:0] tmo;

  logic       pend0;
  logic       pend1;
  logic       pick;
  logic       pick_rd;
  logic       own_rd;
  logic       own_wr;
  logic       own_wen;
  logic [8:0] own_waddr;
  logic [8:0] own_raddr;
  logic [7:0] own_wdata;

  assign pend0 = bus.req0_rd | bus.req0_wr;
  assign pend1 = bus.req1_rd | bus.req1_wr;
  // On contention the port that did not own last wins.
  assign pick = (pend0 & pend1) ? ~last_owner : pend1;
  assign pick_rd = pick ? bus.req1_rd : bus.req0_rd;

  always_comb begin
    if (owner) begin
      own_rd    = bus.req1_rd;
      own_wr    = bus.req1_wr;
      own_wen   = bus.req1_wr_en;
      own_waddr = bus.req1_wr_addr;
      own_wdata = bus.req1_wr_data;
      own_raddr = bus.req1_rd_addr;
    end else begin
      own_rd    = bus.req0_rd;
      own_wr    = bus.req0_wr;
      own_wen   = bus.req0_wr_en;
      own_waddr = bus.req0_wr_addr;
      own_wdata = bus.req0_wr_data;
      own_raddr = bus.req0_rd_addr;
    end
  end

  // A strobe from an owner that has just dropped wr is an abort cycle.
  assign bus.sd_wr_en =
    (state == LOAD) & own_wr & own_wen;
  assign bus.sd_wr_addr =
    (state == LOAD) ? own_waddr : '0;
  assign bus.sd_wr_data =
    (state == LOAD) ? own_wdata : '0;
  assign bus.sd_rd_addr =
    (state == HOLD) ? own_raddr : '0;
  assign bus.rd_data = bus.sd_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      op_rd      <= 1'b0;
      last_owner <= 1'b1;
      strobes    <= '0;
      tmo        <= '0;
      bus.gnt0   <= 1'b0;
      bus.gnt1   <= 1'b0;
      bus.done0  <= 1'b0;
      bus.done1  <= 1'b0;
      bus.err0   <= 1'b0;
      bus.err1   <= 1'b0;
      bus.sd_rd_req <= 1'b0;
      bus.sd_wr_req <= 1'b0;
      bus.sd_lba    <= '0;
    end else begin
      bus.done0     <= 1'b0;
      bus.done1     <= 1'b0;
      bus.err0      <= 1'b0;
      bus.err1      <= 1'b0;
      bus.sd_rd_req <= 1'b0;
      bus.sd_wr_req <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pend0 | pend1) begin
            owner      <= pick;
            last_owner <= pick;
            op_rd      <= pick_rd;
            bus.gnt0   <= ~pick;
            bus.gnt1   <= pick;
            bus.sd_lba <= pick ? bus.req1_lba
                               : bus.req0_lba;
            strobes    <= '0;
            state      <= pick_rd ? ISSUE : LOAD;
          end
        end
        LOAD: begin
          if (!own_wr) begin
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            state    <= IDLE;
          end else if (own_wen) begin
            strobes <= strobes + 10'd1;
            if (strobes == LAST_STB)
              state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.sd_busy) begin
            bus.sd_rd_req <= op_rd;
            bus.sd_wr_req <= ~op_rd;
            tmo           <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          // Completion takes priority over a same-cycle expiry.
          if (bus.sd_done) begin
            bus.done0 <= ~owner;
            bus.done1 <= owner;
            if (op_rd) begin
              state <= HOLD;
            end else begin
              bus.gnt0 <= 1'b0;
              bus.gnt1 <= 1'b0;
              state    <= IDLE;
            end
          end else if (tmo == TMO_LAST) begin
            bus.err0 <= ~owner;
            bus.err1 <= owner;
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            state    <= IDLE;
          end else begin
            tmo <= tmo + 24'd1;
          end
        end
        HOLD: begin
          if (!own_rd) begin
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_arbiter.sv
// Self-checking bench for sd_arbiter: transaction-level model,
// per-cycle compare, directed scenarios and randomized traffic.
module tb_sd_arbiter;
  localparam int TMO  = 100;
  localparam int SECT = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_arbiter_if ifc();

  sd_arbiter #(
    .TIMEOUT_CYCLES(24'(TMO)),
    .SECTOR_BYTES  (SECT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  logic        p_rd[2]    = '{1'b0, 1'b0};
  logic        p_wr[2]    = '{1'b0, 1'b0};
  logic        p_wen[2]   = '{1'b0, 1'b0};
  logic [31:0] p_lba[2]   = '{32'd0, 32'd0};
  logic [8:0]  p_waddr[2] = '{9'd0, 9'd0};
  logic [7:0]  p_wdata[2] = '{8'd0, 8'd0};
  logic [8:0]  p_raddr[2] = '{9'd0, 9'd0};
  logic        sd_busy = 1'b0;
  logic        sd_done = 1'b0;

  assign ifc.req0_rd      = p_rd[0];
  assign ifc.req1_rd      = p_rd[1];
  assign ifc.req0_wr      = p_wr[0];
  assign ifc.req1_wr      = p_wr[1];
  assign ifc.req0_lba     = p_lba[0];
  assign ifc.req1_lba     = p_lba[1];
  assign ifc.req0_wr_en   = p_wen[0];
  assign ifc.req1_wr_en   = p_wen[1];
  assign ifc.req0_wr_addr = p_waddr[0];
  assign ifc.req1_wr_addr = p_waddr[1];
  assign ifc.req0_wr_data = p_wdata[0];
  assign ifc.req1_wr_data = p_wdata[1];
  assign ifc.req0_rd_addr = p_raddr[0];
  assign ifc.req1_rd_addr = p_raddr[1];
  assign ifc.sd_busy      = sd_busy;
  assign ifc.sd_done      = sd_done;
  // Sector buffer stand-in: byte = low address bits xor 0x5A.
  assign ifc.sd_rd_data = ifc.sd_rd_addr[7:0] ^ 8'h5A;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: one transaction record for the current owner.
  int          m_owner = -1;
  int          m_last  = 1;
  bit          m_rd    = 0;
  int          m_stb   = 0;
  int          m_age   = 0;
  bit          m_sent  = 0;
  bit          m_fin   = 0;
  logic        e_gnt[2]  = '{1'b0, 1'b0};
  logic        e_done[2] = '{1'b0, 1'b0};
  logic        e_err[2]  = '{1'b0, 1'b0};
  logic        e_rdreq = 1'b0;
  logic        e_wrreq = 1'b0;
  logic [31:0] e_lba   = 32'd0;

  function automatic bit m_loading();
    return m_owner >= 0 && !m_rd && m_stb < SECT;
  endfunction

  function automatic bit m_holding();
    return m_owner >= 0 && m_rd && m_fin;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_rd = 0;
    m_stb = 0; m_age = 0; m_sent = 0; m_fin = 0;
    e_gnt[0] = 0; e_gnt[1] = 0;
    e_done[0] = 0; e_done[1] = 0;
    e_err[0] = 0; e_err[1] = 0;
    e_rdreq = 0; e_wrreq = 0; e_lba = 0;
  endtask

  task automatic model_step();
    int o;
    bit a0, a1;
    e_done[0] = 0; e_done[1] = 0;
    e_err[0] = 0; e_err[1] = 0;
    e_rdreq = 0; e_wrreq = 0;
    a0 = p_rd[0] | p_wr[0];
    a1 = p_rd[1] | p_wr[1];
    o = m_owner;
    if (m_owner < 0) begin
      if (a0 | a1) begin
        o = (a0 && a1) ? 1 - m_last : (a1 ? 1 : 0);
        m_owner = o; m_last = o;
        m_rd = p_rd[o]; m_stb = 0;
        m_sent = 0; m_fin = 0;
        e_lba = p_lba[o];
      end
    end else if (m_loading()) begin
      if (!p_wr[o]) m_owner = -1;
      else if (p_wen[o]) m_stb++;
    end else if (!m_sent) begin
      if (!sd_busy) begin
        m_sent = 1; m_age = 0;
        e_rdreq = m_rd; e_wrreq = !m_rd;
      end
    end else if (!m_fin) begin
      if (sd_done) begin
        e_done[o] = 1;
        if (m_rd) m_fin = 1;
        else m_owner = -1;
      end else if (m_age == TMO - 1) begin
        e_err[o] = 1;
        m_owner = -1;
      end else begin
        m_age++;
      end
    end else if (!p_rd[o]) begin
      m_owner = -1;
    end
    e_gnt[0] = (m_owner == 0);
    e_gnt[1] = (m_owner == 1);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  task automatic compare();
    int  o;
    bit  xw;
    logic [8:0] xra;
    o = m_owner;
    xw = 0;
    xra = '0;
    if (o >= 0) begin
      xw = m_loading() && p_wr[o] && p_wen[o];
      if (m_holding()) xra = p_raddr[o];
    end
    chk("gnt0", ifc.gnt0, e_gnt[0]);
    chk("gnt1", ifc.gnt1, e_gnt[1]);
    chk("done0", ifc.done0, e_done[0]);
    chk("done1", ifc.done1, e_done[1]);
    chk("err0", ifc.err0, e_err[0]);
    chk("err1", ifc.err1, e_err[1]);
    chk("sd_rd_req", ifc.sd_rd_req, e_rdreq);
    chk("sd_wr_req", ifc.sd_wr_req, e_wrreq);
    chk("sd_lba", ifc.sd_lba, e_lba);
    chk("sd_wr_en", ifc.sd_wr_en, xw);
    if (xw) begin
      chk("sd_wr_addr", ifc.sd_wr_addr, p_waddr[o]);
      chk("sd_wr_data", ifc.sd_wr_data, p_wdata[o]);
    end
    chk("sd_rd_addr", ifc.sd_rd_addr, xra);
    chk("rd_data", ifc.rd_data, ifc.sd_rd_data);
  endtask

  always @(negedge clk) begin
    #4;
    compare();
  end

  int n_rdreq = 0;
  int n_wrreq = 0;
  int n_wen   = 0;
  int n_done0 = 0;
  always @(negedge clk) begin
    #4;
    n_rdreq += int'(ifc.sd_rd_req);
    n_wrreq += int'(ifc.sd_wr_req);
    n_wen   += int'(ifc.sd_wr_en);
    n_done0 += int'(ifc.done0);
  end

  // Controller stand-in: answers a command after a latency (0 = never).
  bit rnd_mode = 0;
  int resp_lat = 0;
  int cd = 0;

  function automatic int rand_lat();
    if ($urandom_range(0, 7) == 0) return 0;
    if ($urandom_range(0, 3) == 0)
      return int'($urandom_range(95, 105));
    return int'($urandom_range(1, 30));
  endfunction

  always @(negedge clk) begin
    sd_done = rnd_mode && ($urandom_range(0, 49) == 0);
    sd_busy = rnd_mode && ($urandom_range(0, 3) == 0);
    if (rst) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) sd_done = 1'b1;
      end
      if (ifc.sd_rd_req || ifc.sd_wr_req)
        cd = rnd_mode ? rand_lat() : resp_lat;
    end
  end

  function automatic logic sigv(input int id);
    case (id)
      0: return ifc.gnt0;
      1: return ifc.gnt1;
      2: return ifc.done0;
      3: return ifc.done1;
      4: return ifc.err0;
      6: return ifc.sd_rd_req;
      7: return ifc.sd_wr_req;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_hi(input int id, input int maxc,
                         input string nm, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      #2;
      if (sigv(id)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_%s: low for %0d cycles, required high",
               nm, maxc);
    end
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < 2; p++) begin
      p_rd[p] = 0; p_wr[p] = 0; p_wen[p] = 0;
      p_lba[p] = 0; p_waddr[p] = 0;
      p_wdata[p] = 0; p_raddr[p] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt0", ifc.gnt0, 0);
    chk("rst_gnt1", ifc.gnt1, 0);
    chk("rst_done", {ifc.done0, ifc.done1}, 0);
    chk("rst_err", {ifc.err0, ifc.err1}, 0);
    chk("rst_cmd", {ifc.sd_rd_req, ifc.sd_wr_req}, 0);
    chk("rst_lba", ifc.sd_lba, 0);
    chk("rst_wr_en", ifc.sd_wr_en, 0);
    chk("rst_rd_addr", ifc.sd_rd_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int rel_cd[2] = '{-1, -1};

  task automatic rand_port(input int p);
    bit comp;
    int k;
    comp = p ? (ifc.done1 | ifc.err1)
             : (ifc.done0 | ifc.err0);
    if (!p_rd[p] && !p_wr[p]) begin
      if ($urandom_range(0, 7) == 0) begin
        k = int'($urandom_range(0, 3));
        p_rd[p] = (k != 2);
        p_wr[p] = (k >= 2);
        p_lba[p] = $urandom;
        rel_cd[p] = -1;
      end
    end else begin
      if (comp) begin
        if (p_rd[p]) rel_cd[p] = int'($urandom_range(0, 8));
        else p_wr[p] = 0;
      end else if (p_wr[p] && !p_rd[p] &&
                   $urandom_range(0, 1999) == 0) begin
        p_wr[p] = 0;
      end
      if (rel_cd[p] == 0) begin
        p_rd[p] = 0; p_wr[p] = 0; rel_cd[p] = -1;
      end else if (rel_cd[p] > 0) begin
        rel_cd[p]--;
      end
    end
    p_wen[p]   = ($urandom_range(0, 3) != 0);
    p_waddr[p] = 9'($urandom);
    p_wdata[p] = 8'($urandom);
    p_raddr[p] = 9'($urandom);
  endtask

  int t0, t1, base, w;
  int wins[4];
  int exp_w[4] = '{0, 1, 0, 1};
  logic [8:0] ra[3] = '{9'h000, 9'h0A5, 9'h1FF};

  initial begin
    do_reset();

    // Port 0 read of LBA 0x1234, controller answers after 20 cycles.
    resp_lat = 20;
    base = n_rdreq;
    @(negedge clk);
    p_rd[0] = 1; p_lba[0] = 32'h0000_1234;
    wait_hi(0, 5, "gnt0", t0);
    chk("rd_lba", ifc.sd_lba, 32'h1234);
    wait_hi(6, 5, "sd_rd_req", t0);
    wait_hi(2, 40, "done0", t1);
    chk("rd_done_delay", t1 - t0, 21);
    chk("rd_req_count", n_rdreq - base, 1);
    for (int i = 0; i < 3; i++) begin
      p_raddr[0] = ra[i];
      #1;
      chk("hold_rd_addr", ifc.sd_rd_addr, ra[i]);
      chk("hold_rd_data", ifc.rd_data,
          {1'b0, ra[i][7:0] ^ 8'h5A});
      @(negedge clk);
      #2;
    end
    p_rd[0] = 0;
    @(negedge clk);
    #2;
    chk("rd_release_gnt0", ifc.gnt0, 0);

    // Port 1 write of LBA 7 with port 0 strobing in between.
    resp_lat = 5;
    base = n_wrreq;
    t0 = n_wen;
    @(negedge clk);
    p_wr[1] = 1; p_lba[1] = 32'd7;
    wait_hi(1, 5, "gnt1", t1);
    chk("wr_lba", ifc.sd_lba, 32'd7);
    for (int i = 0; i < SECT; i++) begin
      @(negedge clk);
      p_wen[0] = 0;
      p_wen[1] = 1;
      p_waddr[1] = 9'(i);
      p_wdata[1] = 8'(i);
      @(negedge clk);
      p_wen[1] = 0;
      p_wen[0] = 1;
      p_waddr[0] = 9'h1AB;
      p_wdata[0] = 8'hEE;
    end
    wait_hi(7, 5, "sd_wr_req", t1);
    p_wen[0] = 0;
    chk("wr_strobes", n_wen - t0, SECT);
    wait_hi(3, 20, "done1", t1);
    p_wr[1] = 0;
    chk("wr_req_count", n_wrreq - base, 1);

    // Simultaneous requests after reset alternate 0,1,0,1.
    do_reset();
    resp_lat = 3;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      p_rd[0] = 1; p_rd[1] = 1;
      w = -1;
      for (int i = 0; i < 5 && w < 0; i++) begin
        @(negedge clk);
        #2;
        if (ifc.gnt0) w = 0;
        else if (ifc.gnt1) w = 1;
      end
      wins[r] = w;
      chk("rr_winner", wins[r], exp_w[r]);
      wait_hi(w == 1 ? 3 : 2, 20, "rr_done", t1);
      p_rd[0] = 0; p_rd[1] = 0;
      repeat (2) @(negedge clk);
    end

    // Controller never answers: error at issue + TIMEOUT.
    resp_lat = 0;
    base = n_done0;
    @(negedge clk);
    p_rd[0] = 1; p_lba[0] = 32'hDEAD_0001;
    wait_hi(6, 10, "tmo_rd_req", t0);
    wait_hi(4, TMO + 20, "err0", t1);
    p_rd[0] = 0;
    chk("tmo_delay", t1 - t0, TMO);
    chk("tmo_no_done", n_done0 - base, 0);
    chk("tmo_gnt0", ifc.gnt0, 0);
    @(negedge clk);
    #2;
    chk("tmo_idle_gnt0", ifc.gnt0, 0);

    // Reset in the middle of a wait, then a normal read.
    @(negedge clk);
    p_rd[1] = 1;
    wait_hi(6, 10, "mid_rd_req", t0);
    repeat (5) @(negedge clk);
    base = n_rdreq;
    do_reset();
    repeat (3) @(negedge clk);
    chk("no_reissue", n_rdreq - base, 0);
    resp_lat = 4;
    p_rd[0] = 1; p_lba[0] = 32'h55;
    wait_hi(0, 5, "post_rst_gnt0", t0);
    chk("post_rst_lba", ifc.sd_lba, 32'h55);
    wait_hi(2, 20, "post_rst_done0", t1);
    p_rd[0] = 0;
    repeat (2) @(negedge clk);

    // Randomized traffic against the model.
    do_reset();
    rnd_mode = 1;
    repeat (8000) begin
      @(negedge clk);
      rand_port(0);
      rand_port(1);
    end
    rnd_mode = 0;
    clear_inputs();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end
endmodule
